// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int SUMADOR_N_DEFAULT = 8;

endpackage

// File: rtl/sumador_1bit.sv
// Single full-adder cell; the serial controller reuses it for every bit position.
module sumador_1bit (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell walks the operands LSB-first
// over N cycles with the carry recirculated through a flip-flop.
module sumador_serial_ctrl
  import sumador_pkg::*;
#(
  parameter int N = SUMADOR_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Co,
  output logic         ovf
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, b_reg;
  logic           carry_reg;
  logic [CW-1:0]  cnt_reg;
  logic           cell_s, cell_co;
  logic [N-1:0]   res_full;
  logic           last_bit;

  sumador_1bit u_cell (
    .A  (a_reg[0]),
    .B  (b_reg[0]),
    .Ci (carry_reg),
    .S  (cell_s),
    .Co (cell_co)
  );

  assign last_bit = (state_reg == SUMA) && (cnt_reg == LAST);

  // Only N-1 partial sum bits need storage; the final bit comes straight
  // from the cell on the last SUMA edge.
  generate
    if (N > 1) begin : g_res
      logic [N-2:0] res_reg;
      assign res_full = {cell_s, res_reg};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_reg <= '0;
        end else if (state_reg == SUMA) begin
          res_reg <= res_full[N-1:1];
        end
      end
    end else begin : g_res1
      assign res_full = cell_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = SUMA;
      end
      SUMA: begin
        if (cnt_reg == LAST) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs load on the final SUMA edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      S         <= '0;
      Co        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_reg     <= A;
        b_reg     <= B;
        carry_reg <= Ci;
        cnt_reg   <= '0;
      end else if (state_reg == SUMA) begin
        a_reg     <= a_reg >> 1;
        b_reg     <= b_reg >> 1;
        carry_reg <= cell_co;
        cnt_reg   <= cnt_reg + CW'(1);
      end
      if (last_bit) begin
        S   <= res_full;
        Co  <= cell_co;
        ovf <= carry_reg ^ cell_co;
      end
    end
  end

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Directed plus randomized checks of the serial adder against an arithmetic
// reference (plain N+1-bit addition and sign-rule overflow).
module tb_sumador_serial_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         Ci = 1'b0;
  logic         busy, done, Co, ovf;
  logic [N-1:0] S;

  int compared = 0;
  int mismatched = 0;

  logic [N-1:0] held_s = '0;
  logic         held_co = 1'b0;
  logic         held_ovf = 1'b0;

  sumador_serial_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Co    (Co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // {ovf, Co, S}: overflow when both operands share a sign the sum does not.
  function automatic logic [N+1:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic ci);
    logic [N:0] sum;
    logic       ov;
    sum = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
    ov  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    return {ov, sum};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                        input bit junk, input string tag);
    logic [N+1:0] r;
    int k;
    r = ref_add(a, b, ci);
    @(negedge clk);
    start = 1'b1; A = a; B = b; Ci = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = N'($urandom); B = N'($urandom); Ci = 1'($urandom);
    @(negedge clk);
    k = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && k < N + 4) begin
      chk({tag, "_hold"}, 32'({ovf, Co, S}), 32'({held_ovf, held_co, held_s}));
      if (junk) begin
        start = 1'($urandom_range(0, 1));
        A = N'($urandom); B = N'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(N));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_result"}, 32'({ovf, Co, S}), 32'(r));
    $display("op %s: A=%h B=%h Ci=%0d -> S=%h Co=%0d ovf=%0d (ref %h)", tag, a, b, ci, S, Co, ovf, r);
    held_s = r[N-1:0]; held_co = r[N]; held_ovf = r[N+1];
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int gap;
    logic [N+1:0] r;

    // Reset held with start asserted
    rst_n = 1'b0; start = 1'b1; A = 8'hFF; B = 8'hFF; Ci = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({busy, done, ovf, Co, S}), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_release_idle", 32'({busy, done}), 32'd0);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "carry1");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "carry2");
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, "ovf_ci");
    run_op(8'h3C, 8'h5A, 1'b0, 1'b1, "busy_ignore");

    // Abort in the 4th SUMA cycle
    @(negedge clk);
    start = 1'b1; A = 8'h12; B = 8'h34; Ci = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midop_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_outs", 32'({busy, done, ovf, Co, S}), 32'd0);
    held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h55, 8'hAA, 1'b1, 1'b0, "after_rst");

    for (int i = 0; i < 12; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // start held high: back-to-back operations every N+2 cycles
    @(negedge clk);
    start = 1'b1; A = 8'hC3; B = 8'h9E; Ci = 1'b1;
    r = ref_add(8'hC3, 8'h9E, 1'b1);
    k = 0;
    while (!done && k < 3 * N) begin
      @(negedge clk);
      k++;
    end
    chk("held_first_done", 32'(done), 32'd1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap < 3 * N);
    start = 1'b0;
    chk("held_gap", 32'(gap), 32'(N + 2));
    chk("held_result", 32'({ovf, Co, S}), 32'(r));
    $display("op held: gap=%0d S=%h Co=%0d ovf=%0d (ref %h)", gap, S, Co, ovf, r);
    repeat (2) @(negedge clk);
    chk("held_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
